// File: rtl/const_shift_pkg.sv
// Shared widths, result/operand field offsets and decoder state encoding
// for the const_shift packing and its decoder.
package const_shift_pkg;
   localparam int W  = 8;
   localparam int SW = 3;

   // res_flat carries three W-bit fields; slot n occupies [n*W +: W]
   localparam int RES_SHL_SLOT  = 2;
   localparam int RES_SHR_SLOT  = 1;
   localparam int RES_ASHR_SLOT = 0;

   // op_flat: shift amount at the bottom, recovered data directly above it
   localparam int OP_AMT_LSB = 0;

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} dec_state_t;
endpackage

// File: rtl/const_shift_candidate_chk.sv
// Combinational test of one candidate shift amount: rebuilds the data word
// from the shl/shr fields and checks it reproduces all three results.
module const_shift_candidate_chk #(
   parameter int W  = const_shift_pkg::W,
   parameter int SW = const_shift_pkg::SW
) (
   input  logic [W-1:0]  shl_i,
   input  logic [W-1:0]  shr_i,
   input  logic [W-1:0]  ashr_i,
   input  logic [SW-1:0] s_i,
   output logic [W-1:0]  d_o,
   output logic          match_o
);
   logic [W-1:0] d_shl;
   logic [W-1:0] d_shr;
   logic [W-1:0] d_ashr;

   always_comb begin
      // Bits covered by neither shifted field stay 0 (the unobservable middle)
      d_o     = (shr_i << s_i) | (shl_i >> s_i);
      d_shl   = d_o << s_i;
      d_shr   = d_o >> s_i;
      d_ashr  = $signed(d_o) >>> s_i;
      match_o = (d_shl == shl_i) && (d_shr == shr_i) && (d_ashr == ashr_i);
   end
endmodule

// File: rtl/const_shift_decoder.sv
// Inverts the const_shift result packing by searching shift amounts one per
// cycle. Define CONST_SHIFT_DEC_AMBIG_EN for a full search with op_ambig.
module const_shift_decoder #(
   parameter int W         = const_shift_pkg::W,
   parameter int MAX_SHIFT = W - 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3*W-1:0]          res_flat,
   input  logic                    res_valid,
   output logic                    res_ready,
   output logic [W+$clog2(W)-1:0]  op_flat,
   output logic                    op_valid,
   input  logic                    op_ready,
   output logic                    op_err,
`ifdef CONST_SHIFT_DEC_AMBIG_EN
   output logic                    op_ambig,
`endif
   output logic                    op_partial
);
   import const_shift_pkg::*;

   localparam int AMT_W = $clog2(W);
   localparam logic [AMT_W-1:0] MAX_S = AMT_W'(MAX_SHIFT);

   dec_state_t       state_q, state_d;
   logic [AMT_W-1:0] s_q, s_d;
   logic [3*W-1:0]   word_q, word_d;
   logic [W-1:0]     data_q, data_d;
   logic [AMT_W-1:0] amt_q, amt_d;
   logic             err_q, err_d;
   logic             partial_q, partial_d;
   logic             op_valid_q, op_valid_d;
`ifdef CONST_SHIFT_DEC_AMBIG_EN
   logic             found_q, found_d;
   logic             ambig_q, ambig_d;
`endif

   logic [W-1:0]     cand_d;
   logic             cand_match;

   const_shift_candidate_chk #(.W(W), .SW(AMT_W)) u_chk (
      .shl_i   (word_q[RES_SHL_SLOT*W  +: W]),
      .shr_i   (word_q[RES_SHR_SLOT*W  +: W]),
      .ashr_i  (word_q[RES_ASHR_SLOT*W +: W]),
      .s_i     (s_q),
      .d_o     (cand_d),
      .match_o (cand_match)
   );

   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      word_d     = word_q;
      data_d     = data_q;
      amt_d      = amt_q;
      err_d      = err_q;
      partial_d  = partial_q;
      op_valid_d = 1'b0;
      res_ready  = 1'b0;
`ifdef CONST_SHIFT_DEC_AMBIG_EN
      found_d    = found_q;
      ambig_d    = ambig_q;
`endif
      case (state_q)
         IDLE: begin
            res_ready = 1'b1;
            if (res_valid) begin
               word_d  = res_flat;
               s_d     = '0;
               state_d = SEARCH;
`ifdef CONST_SHIFT_DEC_AMBIG_EN
               found_d = 1'b0;
               ambig_d = 1'b0;
`endif
            end
         end
         SEARCH: begin
`ifdef CONST_SHIFT_DEC_AMBIG_EN
            // Keep the smallest match; any later match only flags ambiguity
            if (cand_match) begin
               found_d = 1'b1;
               if (found_q) begin
                  ambig_d = 1'b1;
               end else begin
                  data_d    = cand_d;
                  amt_d     = s_q;
                  err_d     = 1'b0;
                  partial_d = (2 * int'(s_q)) > W;
               end
            end
            if (s_q == MAX_S) begin
               state_d = DONE;
               if (!found_q && !cand_match) begin
                  data_d    = '0;
                  amt_d     = '0;
                  err_d     = 1'b1;
                  partial_d = 1'b0;
               end
            end else begin
               s_d = s_q + AMT_W'(1);
            end
`else
            if (cand_match) begin
               data_d    = cand_d;
               amt_d     = s_q;
               err_d     = 1'b0;
               partial_d = (2 * int'(s_q)) > W;
               state_d   = DONE;
            end else if (s_q == MAX_S) begin
               data_d    = '0;
               amt_d     = '0;
               err_d     = 1'b1;
               partial_d = 1'b0;
               state_d   = DONE;
            end else begin
               s_d = s_q + AMT_W'(1);
            end
`endif
         end
         DONE: begin
            // op_valid is registered, so it rises one cycle after entering DONE
            if (op_valid_q && op_ready) state_d = IDLE;
            else                        op_valid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         s_q        <= '0;
         word_q     <= '0;
         data_q     <= '0;
         amt_q      <= '0;
         err_q      <= 1'b0;
         partial_q  <= 1'b0;
         op_valid_q <= 1'b0;
`ifdef CONST_SHIFT_DEC_AMBIG_EN
         found_q    <= 1'b0;
         ambig_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         word_q     <= word_d;
         data_q     <= data_d;
         amt_q      <= amt_d;
         err_q      <= err_d;
         partial_q  <= partial_d;
         op_valid_q <= op_valid_d;
`ifdef CONST_SHIFT_DEC_AMBIG_EN
         found_q    <= found_d;
         ambig_q    <= ambig_d;
`endif
      end
   end

   assign op_flat[OP_AMT_LSB +: AMT_W]       = amt_q;
   assign op_flat[OP_AMT_LSB + AMT_W +: W]   = data_q;
   assign op_valid   = op_valid_q;
   assign op_err     = err_q;
   assign op_partial = partial_q;
`ifdef CONST_SHIFT_DEC_AMBIG_EN
   assign op_ambig   = ambig_q;
`endif
endmodule

// File: tb/tb_const_shift_decoder.sv
// Bench for const_shift_decoder: directed vector table, backpressure and
// reset corner cases, then randomized words checked against a brute-force model.
`timescale 1ns/1ps
module tb_const_shift_decoder;
   localparam int W         = 8;
   localparam int SW        = 3;
   localparam int MAX_SHIFT = 7;

   logic              clk = 1'b0;
   logic              rst;
   logic [3*W-1:0]    res_flat;
   logic              res_valid;
   logic              res_ready;
   logic [W+SW-1:0]   op_flat;
   logic              op_valid;
   logic              op_ready;
   logic              op_err;
   logic              op_partial;
   logic              op_ambig;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [23:0] res;
      logic [7:0]  data;
      logic [2:0]  amt;
      logic        err;
      logic        partial;
      logic        ambig;
      int          lat;
      int          hold;
   } vec_t;

   vec_t vecs[4];

`ifndef CONST_SHIFT_DEC_AMBIG_EN
   assign op_ambig = 1'b0;
`endif

   const_shift_decoder dut (
      .clk        (clk),
      .rst        (rst),
      .res_flat   (res_flat),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .op_flat    (op_flat),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_err     (op_err),
`ifdef CONST_SHIFT_DEC_AMBIG_EN
      .op_ambig   (op_ambig),
`endif
      .op_partial (op_partial)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Forward brute force: try every data value at every shift amount.
   task automatic model(input logic [23:0] res, output logic [7:0] data, output logic [2:0] amt,
                        output logic err, output logic partial, output logic ambig, output int lat);
      int         nmatch;
      logic       found;
      logic       hit;
      logic [7:0] xv, x_hit, a, b, c, mask;
      nmatch = 0; found = 1'b0;
      data = '0; amt = '0; err = 1'b1; partial = 1'b0; ambig = 1'b0;
      for (int s = 0; s <= MAX_SHIFT; s++) begin
         hit = 1'b0; x_hit = '0;
         for (int x = 0; x < 256; x++) begin
            xv = x[7:0];
            a = xv << s;
            b = xv >> s;
            c = $signed(xv) >>> s;
            if ({a, b, c} == res) begin hit = 1'b1; x_hit = xv; end
         end
         if (hit) begin
            nmatch++;
            if (!found) begin
               found = 1'b1;
               mask  = '0;
               for (int k = W - s; k < s; k++) mask[k] = 1'b1;
               data    = x_hit & ~mask;
               amt     = s[2:0];
               err     = 1'b0;
               partial = (2 * s) > W;
            end
         end
      end
      ambig = nmatch > 1;
`ifdef CONST_SHIFT_DEC_AMBIG_EN
      lat = MAX_SHIFT + 2;
`else
      lat = err ? MAX_SHIFT + 2 : int'(amt) + 2;
`endif
   endtask

   task automatic run_word(input logic [23:0] res, input logic [7:0] e_data, input logic [2:0] e_amt,
                           input logic e_err, input logic e_partial, input logic e_ambig,
                           input int e_lat, input int hold);
      int k;
      int lat;
      logic [W+SW-1:0] held;
      k = 0;
      @(negedge clk);
      while (!res_ready && k < 50) begin @(negedge clk); k++; end
      check("ready_before_accept", {31'd0, res_ready}, 32'd1);
      if (!res_ready) return;
      res_flat  = res;
      res_valid = 1'b1;
      @(posedge clk);
      #1 res_valid = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!op_valid && lat < 40) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      check("latency", lat, e_lat);
      if (!op_valid) return;
      check("op_flat", {21'd0, op_flat}, {21'd0, e_data, e_amt});
      check("op_err", {31'd0, op_err}, {31'd0, e_err});
      check("op_partial", {31'd0, op_partial}, {31'd0, e_partial});
`ifdef CONST_SHIFT_DEC_AMBIG_EN
      check("op_ambig", {31'd0, op_ambig}, {31'd0, e_ambig});
`endif
      held = op_flat;
      // While stalled, offer a garbage word that must be ignored
      for (int i = 0; i < hold; i++) begin
         res_flat  = 24'($urandom);
         res_valid = 1'b1;
         @(posedge clk); @(negedge clk);
         check("stall_valid", {31'd0, op_valid}, 32'd1);
         check("stall_flat", {21'd0, op_flat}, {21'd0, held});
         check("stall_res_ready", {31'd0, res_ready}, 32'd0);
      end
      op_ready = 1'b1;
      @(posedge clk);
      #1 op_ready = 1'b0;
      res_valid = 1'b0;
      @(negedge clk);
      check("post_hs_valid", {31'd0, op_valid}, 32'd0);
      check("post_hs_ready", {31'd0, res_ready}, 32'd1);
   endtask

   initial begin
      logic [7:0]  m_data;
      logic [2:0]  m_amt;
      logic        m_err, m_partial, m_ambig;
      int          m_lat;
      logic [23:0] word;
      logic [7:0]  x;
      int          s;
      int          pulses;

`ifdef CONST_SHIFT_DEC_AMBIG_EN
      vecs[0] = '{24'h4434F4, 8'hD1, 3'd2, 1'b0, 1'b0, 1'b0, 9, 5};
      vecs[1] = '{24'h000000, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 9, 0};
      vecs[2] = '{24'hC003FF, 8'hC3, 3'd6, 1'b0, 1'b1, 1'b0, 9, 1};
      vecs[3] = '{24'h018000, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 9, 0};
`else
      vecs[0] = '{24'h4434F4, 8'hD1, 3'd2, 1'b0, 1'b0, 1'b0, 4, 5};
      vecs[1] = '{24'h000000, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 2, 0};
      vecs[2] = '{24'hC003FF, 8'hC3, 3'd6, 1'b0, 1'b1, 1'b0, 8, 1};
      vecs[3] = '{24'h018000, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 9, 0};
`endif

      rst = 1'b1; res_flat = '0; res_valid = 1'b0; op_ready = 1'b0;
      #12;
      check("rst_res_ready", {31'd0, res_ready}, 32'd1);
      check("rst_op_valid", {31'd0, op_valid}, 32'd0);
      check("rst_op_flat", {21'd0, op_flat}, 32'd0);
      check("rst_op_err", {31'd0, op_err}, 32'd0);
      check("rst_op_partial", {31'd0, op_partial}, 32'd0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 4; i++)
         run_word(vecs[i].res, vecs[i].data, vecs[i].amt, vecs[i].err, vecs[i].partial,
                  vecs[i].ambig, vecs[i].lat, vecs[i].hold);

      // Reset two cycles into a long search: result must never appear
      @(negedge clk);
      res_flat = 24'h018000; res_valid = 1'b1;
      @(posedge clk);
      #1 res_valid = 1'b0;
      @(posedge clk); @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_op_valid", {31'd0, op_valid}, 32'd0);
      check("midrst_res_ready", {31'd0, res_ready}, 32'd1);
      check("midrst_op_flat", {21'd0, op_flat}, 32'd0);
      check("midrst_op_err", {31'd0, op_err}, 32'd0);
      @(negedge clk); rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (op_valid) pulses++;
      end
      check("midrst_no_pulse", pulses, 0);
      check("midrst_idle_ready", {31'd0, res_ready}, 32'd1);

      // Random round trips and random (mostly inconsistent) raw words
      for (int i = 0; i < 40; i++) begin
         if (i % 2 == 0) begin
            x = 8'($urandom);
            s = $urandom_range(0, MAX_SHIFT);
            word = {8'(x << s), 8'(x >> s), 8'($signed(x) >>> s)};
         end else begin
            word = 24'($urandom);
         end
         model(word, m_data, m_amt, m_err, m_partial, m_ambig, m_lat);
         run_word(word, m_data, m_amt, m_err, m_partial, m_ambig, m_lat, $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
